// File: rtl/sysid_verifier_pkg.sv
// Shared types and constants for the system-ID verifier.
// Optional watchdog: define SYSID_VERIFIER_TIMEOUT_EN to compile it in.
package sysid_verifier_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ID_REQ  = 3'd1,
        ID_WAIT = 3'd2,
        TS_REQ  = 3'd3,
        TS_WAIT = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Word selects on the sysid control slave
    localparam logic ADDR_ID        = 1'b0;
    localparam logic ADDR_TIMESTAMP = 1'b1;

    // Values the sysid slave is expected to return for this build
    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'h426F12EC;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'h48FD7552;

    // Width of the stall watchdog counter
    localparam int WATCHDOG_WIDTH = 16;

endpackage

// File: rtl/sysid_verifier_if.sv
// Avalon-MM read-only bus between the verifier (master) and the sysid slave.
interface sysid_verifier_if;

    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface

// File: rtl/sysid_read_engine.sv
// Single-read Avalon handshake: read strobe, acceptance detect, read-latency
// counter and (with SYSID_VERIFIER_TIMEOUT_EN) a stall watchdog.
// The caller says whether it is in a request or a wait phase; the engine
// reports acceptance, the data-capture cycle and watchdog expiry.
module sysid_read_engine
    import sysid_verifier_pkg::*;
#(
    parameter int READ_LATENCY = 1
`ifdef SYSID_VERIFIER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic req_active,
    input  logic wait_active,
    input  logic waitrequest,
    output logic read,
    output logic accept,
    output logic capture,
    output logic expire
);

    // Last wait-phase count value, i.e. the cycle in which readdata is valid
    localparam logic [1:0] LAT_LAST = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

    logic [1:0] lat_cnt_reg;
    logic [1:0] lat_cnt_next;

    assign read   = req_active;
    assign accept = req_active && !waitrequest;

    // Zero latency: data is valid in the acceptance cycle itself
    assign capture = (READ_LATENCY == 0) ? accept
                                         : (wait_active && (lat_cnt_reg == LAT_LAST));

    // Latency counter runs only during the wait phase and restarts for each read
    always_comb begin
        lat_cnt_next = 2'd0;
        if (wait_active && !capture) begin
            lat_cnt_next = lat_cnt_reg + 2'd1;
        end
    end

    // Latency counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt_reg <= 2'd0;
        end else begin
            lat_cnt_reg <= lat_cnt_next;
        end
    end

`ifdef SYSID_VERIFIER_TIMEOUT_EN
    localparam logic [WATCHDOG_WIDTH-1:0] WD_LAST = WATCHDOG_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [WATCHDOG_WIDTH-1:0] wd_cnt_reg;
    logic [WATCHDOG_WIDTH-1:0] wd_cnt_next;

    // Expiry fires on the stalled cycle that brings the count to TIMEOUT_CYCLES
    assign expire = req_active && waitrequest && (wd_cnt_reg == WD_LAST);

    // Count consecutive stalled request cycles; any non-stalled or non-request
    // cycle clears it, so every request phase starts from zero
    always_comb begin
        wd_cnt_next = '0;
        if (req_active && waitrequest && !expire) begin
            wd_cnt_next = wd_cnt_reg + 1'b1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_next;
        end
    end
`else
    assign expire = 1'b0;
`endif

endmodule

// File: rtl/sysid_verifier.sv
// System-ID verifier: reads sysid word 0 (ID) and word 1 (build timestamp)
// over Avalon-MM and compares them against expected values.
// Optional watchdog and timeout port: define SYSID_VERIFIER_TIMEOUT_EN.
module sysid_verifier
    import sysid_verifier_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter int          READ_LATENCY       = 1,
`ifdef SYSID_VERIFIER_TIMEOUT_EN
    parameter int          TIMEOUT_CYCLES     = 255,
`endif
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             id_ok,
    output logic             ts_ok,
`ifdef SYSID_VERIFIER_TIMEOUT_EN
    output logic             timeout,
`endif
    output logic [31:0]      captured_id,
    output logic [31:0]      captured_ts,
    sysid_verifier_if.master avm
);

    state_t      state_reg;
    state_t      state_next;
    logic        auto_pending_reg;
    logic        start_eff;
    logic        req_active;
    logic        wait_active;
    logic        in_id_phase;
    logic        enter_id_req;
    logic        enter_done;
    logic        eng_read;
    logic        accept;
    logic        capture;
    logic        expire;
    logic        id_ok_reg;
    logic        ts_ok_reg;
    logic [31:0] captured_id_reg;
    logic [31:0] captured_ts_reg;

    assign start_eff    = start || auto_pending_reg;
    assign req_active   = (state_reg == ID_REQ)  || (state_reg == TS_REQ);
    assign wait_active  = (state_reg == ID_WAIT) || (state_reg == TS_WAIT);
    assign in_id_phase  = (state_reg == ID_REQ)  || (state_reg == ID_WAIT);
    assign enter_id_req = (state_next == ID_REQ) && (state_reg != ID_REQ);
    assign enter_done   = (state_next == DONE)   && (state_reg != DONE);

    sysid_read_engine #(
        .READ_LATENCY   (READ_LATENCY)
`ifdef SYSID_VERIFIER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_read_engine (
        .clk         (clk),
        .reset       (reset),
        .req_active  (req_active),
        .wait_active (wait_active),
        .waitrequest (avm.avm_waitrequest),
        .read        (eng_read),
        .accept      (accept),
        .capture     (capture),
        .expire      (expire)
    );

    // Auto-start: the first cycle out of reset acts like a start request
    always_ff @(posedge clk) begin
        if (reset) begin
            auto_pending_reg <= AUTO_START;
        end else begin
            auto_pending_reg <= 1'b0;
        end
    end

    // Sequencing state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: ID read, then timestamp read, then DONE; start only
    // honoured when not busy
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start_eff) begin
                    state_next = ID_REQ;
                end
            end
            ID_REQ: begin
                if (expire) begin
                    state_next = DONE;
                end else if (accept) begin
                    state_next = (READ_LATENCY == 0) ? TS_REQ : ID_WAIT;
                end
            end
            ID_WAIT: begin
                if (capture) begin
                    state_next = TS_REQ;
                end
            end
            TS_REQ: begin
                if (expire) begin
                    state_next = DONE;
                end else if (accept) begin
                    state_next = (READ_LATENCY == 0) ? DONE : TS_WAIT;
                end
            end
            TS_WAIT: begin
                if (capture) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture read data and register the compares on entry to DONE; the
    // timestamp compare uses the word arriving in that same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            captured_id_reg <= 32'd0;
            captured_ts_reg <= 32'd0;
            id_ok_reg       <= 1'b0;
            ts_ok_reg       <= 1'b0;
        end else begin
            if (capture && in_id_phase) begin
                captured_id_reg <= avm.avm_readdata;
            end
            if (capture && !in_id_phase) begin
                captured_ts_reg <= avm.avm_readdata;
            end
            if (enter_id_req) begin
                id_ok_reg <= 1'b0;
                ts_ok_reg <= 1'b0;
            end else if (enter_done) begin
                id_ok_reg <= !expire && (captured_id_reg == EXPECTED_ID);
                ts_ok_reg <= !expire && (avm.avm_readdata == EXPECTED_TIMESTAMP);
            end
        end
    end

`ifdef SYSID_VERIFIER_TIMEOUT_EN
    logic timeout_reg;

    // Timeout flag: set by a watchdog abort, cleared when a new check starts
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_reg <= 1'b0;
        end else if (enter_id_req) begin
            timeout_reg <= 1'b0;
        end else if (enter_done) begin
            timeout_reg <= expire;
        end
    end

    assign timeout = timeout_reg;
`endif

    assign busy            = req_active || wait_active;
    assign done            = (state_reg == DONE);
    assign id_ok           = id_ok_reg;
    assign ts_ok           = ts_ok_reg;
    assign captured_id     = captured_id_reg;
    assign captured_ts     = captured_ts_reg;
    assign avm.avm_read    = eng_read;
    assign avm.avm_address = (state_reg == TS_REQ) ? ADDR_TIMESTAMP : ADDR_ID;

endmodule

// File: tb/tb_sysid_verifier.sv
// Testbench for sysid_verifier: reactive sysid slave, timeline-based model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_sysid_verifier;

    localparam int          LAT    = 1;
    localparam bit          AUTO   = 1'b1;
    localparam logic [31:0] EXP_ID = 32'h426F12EC;
    localparam logic [31:0] EXP_TS = 32'h48FD7552;
    localparam int          BIG    = 1 << 30;
`ifdef SYSID_VERIFIER_TIMEOUT_EN
    localparam int          TMO    = 10;
`else
    localparam int          TMO    = BIG;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
`ifdef SYSID_VERIFIER_TIMEOUT_EN
    logic        timeout;
`endif
    logic [31:0] captured_id;
    logic [31:0] captured_ts;

    sysid_verifier_if bus ();

    sysid_verifier #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .READ_LATENCY       (LAT),
`ifdef SYSID_VERIFIER_TIMEOUT_EN
        .TIMEOUT_CYCLES     (TMO),
`endif
        .AUTO_START         (AUTO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .id_ok       (id_ok),
        .ts_ok       (ts_ok),
`ifdef SYSID_VERIFIER_TIMEOUT_EN
        .timeout     (timeout),
`endif
        .captured_id (captured_id),
        .captured_ts (captured_ts),
        .avm         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave configuration shared by the slave and the model
    logic [31:0] word0_cfg;
    logic [31:0] word1_cfg;
    int          stall0_cfg;
    int          stall1_cfg;
    int          rd_log[$];

    // Sysid slave: stalls each new read by the configured count, returns data
    // one cycle after acceptance, garbage otherwise
    bit s_in_read;
    int s_stall_left;
    bit s_pend;
    bit s_pend_addr;
    initial begin
        s_in_read = 0; s_stall_left = 0; s_pend = 0; s_pend_addr = 0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            bus.avm_readdata = s_pend ? (s_pend_addr ? word1_cfg : word0_cfg) : 32'hDEADBEEF;
            s_pend = 0;
            if (bus.avm_read === 1'b1) begin
                if (!s_in_read) begin
                    s_in_read    = 1;
                    s_stall_left = (bus.avm_address === 1'b1) ? stall1_cfg : stall0_cfg;
                end
                if (s_stall_left > 0) begin
                    bus.avm_waitrequest = 1'b1;
                    s_stall_left--;
                end else begin
                    bus.avm_waitrequest = 1'b0;
                    s_in_read   = 0;
                    s_pend      = 1;
                    s_pend_addr = (bus.avm_address === 1'b1);
                    rd_log.push_back((bus.avm_address === 1'b1) ? 1 : 0);
                end
            end else begin
                s_in_read           = 0;
                bus.avm_waitrequest = 1'b0;
            end
        end
    end

    // Model: a check started at cycle s is a fixed timeline of read windows
    // derived from stall counts and latency
    bit          chk_en, m_active, m_auto, m_done, m_id_ok, m_ts_ok, m_to, to0, to1;
    logic [31:0] m_cap_id, m_cap_ts, m_w0, m_w1;
    int          m_s, k, a0, rd0_end, rd1_start, rd1_end, cap0_k, done_k;
    bit          e_read, e_addr;

    initial begin
        chk_en = 0; m_active = 0; m_auto = 0; m_done = 0; m_id_ok = 0; m_ts_ok = 0; m_to = 0;
        m_cap_id = '0; m_cap_ts = '0;
        forever begin
            @(negedge clk);
            #3;
            if (m_active && (cyc - m_s) == done_k) begin
                m_active = 0;
                m_done   = 1;
                m_to     = to0 || to1;
                m_id_ok  = !m_to && (m_w0 == EXP_ID);
                m_ts_ok  = !m_to && (m_w1 == EXP_TS);
                if (!to0) m_cap_id = m_w0;
                if (!to0 && !to1) m_cap_ts = m_w1;
            end
            if (chk_en) begin
                if (m_active) begin
                    k      = cyc - m_s;
                    e_read = (k >= 1 && k <= rd0_end) || (k >= rd1_start && k <= rd1_end);
                    e_addr = (k >= rd1_start);
                    check("busy", {31'd0, busy}, 32'd1);
                    check("done", {31'd0, done}, 32'd0);
                    check("id_ok", {31'd0, id_ok}, 32'd0);
                    check("ts_ok", {31'd0, ts_ok}, 32'd0);
                    check("captured_id", captured_id, (k >= cap0_k) ? m_w0 : m_cap_id);
                    check("captured_ts", captured_ts, m_cap_ts);
                    check("avm_read", {31'd0, bus.avm_read}, {31'd0, e_read});
                    if (e_read) check("avm_address", {31'd0, bus.avm_address}, {31'd0, e_addr});
`ifdef SYSID_VERIFIER_TIMEOUT_EN
                    check("timeout", {31'd0, timeout}, 32'd0);
`endif
                end else begin
                    check("busy", {31'd0, busy}, 32'd0);
                    check("done", {31'd0, done}, {31'd0, m_done});
                    check("id_ok", {31'd0, id_ok}, {31'd0, m_id_ok});
                    check("ts_ok", {31'd0, ts_ok}, {31'd0, m_ts_ok});
                    check("captured_id", captured_id, m_cap_id);
                    check("captured_ts", captured_ts, m_cap_ts);
                    check("avm_read", {31'd0, bus.avm_read}, 32'd0);
`ifdef SYSID_VERIFIER_TIMEOUT_EN
                    check("timeout", {31'd0, timeout}, {31'd0, m_to});
`endif
                end
            end
            if (reset === 1'b1) begin
                chk_en = 1; m_active = 0; m_auto = AUTO;
                m_done = 0; m_id_ok = 0; m_ts_ok = 0; m_to = 0;
                m_cap_id = '0; m_cap_ts = '0;
            end else begin
                if (!m_active && (start === 1'b1 || m_auto)) begin
                    m_active = 1;
                    m_s  = cyc;
                    m_w0 = word0_cfg;
                    m_w1 = word1_cfg;
                    a0   = 1 + stall0_cfg;
                    if (stall0_cfg >= TMO) begin
                        to0 = 1; to1 = 0;
                        rd0_end = TMO; rd1_start = BIG; rd1_end = 0; cap0_k = BIG;
                        done_k = TMO + 1;
                    end else begin
                        to0 = 0;
                        rd0_end   = a0;
                        cap0_k    = a0 + LAT + 1;
                        rd1_start = a0 + LAT + 1;
                        if (stall1_cfg >= TMO) begin
                            to1 = 1;
                            rd1_end = rd1_start + TMO - 1;
                            done_k  = rd1_start + TMO;
                        end else begin
                            to1 = 0;
                            rd1_end = rd1_start + stall1_cfg;
                            done_k  = rd1_end + LAT + 1;
                        end
                    end
                end
                m_auto = 0;
            end
        end
    end

    // Advance to posedge+2 of the given cycle
    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #2;
        end
    endtask

    int s;
    int d;

    initial begin
        reset = 1'b1; start = 1'b0;
        word0_cfg = EXP_ID; word1_cfg = EXP_TS; stall0_cfg = 0; stall1_cfg = 0;
        repeat (3) @(posedge clk);
        #2;

        // Auto check after reset release
        rd_log.delete();
        reset = 1'b0;
        s = cyc;
        wait_to(s + 4);
        $display("auto: cycle+4 done=%0b busy=%0b", done, busy);
        check("auto_done_c4", {31'd0, done}, 32'd0);
        wait_to(s + 5);
        $display("auto: cycle+5 done=%0b id_ok=%0b ts_ok=%0b reads=%0d", done, id_ok, ts_ok, rd_log.size());
        check("auto_done_c5", {31'd0, done}, 32'd1);
        check("auto_id_ok", {31'd0, id_ok}, 32'd1);
        check("auto_ts_ok", {31'd0, ts_ok}, 32'd1);
        check("auto_nreads", rd_log.size(), 32'd2);
        if (rd_log.size() == 2) begin
            check("auto_addr0", rd_log[0], 32'd0);
            check("auto_addr1", rd_log[1], 32'd1);
        end
        check("auto_cap_ts", captured_ts, 32'h48FD7552);

        // Wrong ID word
        wait_to(s + 7);
        word0_cfg = 32'h426F12ED;
        start = 1'b1;
        s = cyc;
        wait_to(s + 1);
        start = 1'b0;
        wait_to(s + 5);
        $display("bad id: done=%0b id_ok=%0b ts_ok=%0b captured_id=%h", done, id_ok, ts_ok, captured_id);
        check("badid_done", {31'd0, done}, 32'd1);
        check("badid_id_ok", {31'd0, id_ok}, 32'd0);
        check("badid_ts_ok", {31'd0, ts_ok}, 32'd1);
        check("badid_cap_id", captured_id, 32'h426F12ED);

        // Three stall cycles on each read
        wait_to(s + 7);
        word0_cfg = EXP_ID; stall0_cfg = 3; stall1_cfg = 3;
        rd_log.delete();
        start = 1'b1;
        s = cyc;
        wait_to(s + 1);
        start = 1'b0;
        wait_to(s + 10);
        check("stall_done_c10", {31'd0, done}, 32'd0);
        wait_to(s + 11);
        $display("stall: cycle+11 done=%0b id_ok=%0b ts_ok=%0b reads=%0d", done, id_ok, ts_ok, rd_log.size());
        check("stall_done_c11", {31'd0, done}, 32'd1);
        check("stall_id_ok", {31'd0, id_ok}, 32'd1);
        check("stall_nreads", rd_log.size(), 32'd2);
        stall0_cfg = 0; stall1_cfg = 0;

        // start held high through a whole check, then a fresh pulse
        wait_to(s + 13);
        rd_log.delete();
        start = 1'b1;
        s = cyc;
        wait_to(s + 1);
        check("hold_busy", {31'd0, busy}, 32'd1);
        wait_to(s + 5);
        start = 1'b0;
        check("hold_done", {31'd0, done}, 32'd1);
        wait_to(s + 8);
        $display("hold: done=%0b busy=%0b reads=%0d", done, busy, rd_log.size());
        check("hold_done_stays", {31'd0, done}, 32'd1);
        check("hold_nreads", rd_log.size(), 32'd2);
        start = 1'b1;
        d = cyc;
        wait_to(d + 1);
        start = 1'b0;
        check("restart_done_clr", {31'd0, done}, 32'd0);
        check("restart_busy", {31'd0, busy}, 32'd1);
        wait_to(d + 5);
        check("restart_done", {31'd0, done}, 32'd1);

        // Reset (together with start) during TS_WAIT, then auto restart
        wait_to(d + 7);
        start = 1'b1;
        s = cyc;
        wait_to(s + 1);
        start = 1'b0;
        wait_to(s + 4);
        reset = 1'b1;
        start = 1'b1;
        wait_to(s + 5);
        reset = 1'b0;
        start = 1'b0;
        $display("reset: busy=%0b done=%0b cap_id=%h read=%0b", busy, done, captured_id, bus.avm_read);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_id_ok", {31'd0, id_ok}, 32'd0);
        check("rst_ts_ok", {31'd0, ts_ok}, 32'd0);
        check("rst_cap_id", captured_id, 32'd0);
        check("rst_cap_ts", captured_ts, 32'd0);
        check("rst_read", {31'd0, bus.avm_read}, 32'd0);
        check("rst_addr", {31'd0, bus.avm_address}, 32'd0);
        wait_to(s + 10);
        check("rst_auto_done", {31'd0, done}, 32'd1);
        check("rst_auto_id_ok", {31'd0, id_ok}, 32'd1);

`ifdef SYSID_VERIFIER_TIMEOUT_EN
        // Slave stalls forever: watchdog aborts after TMO stalled cycles
        wait_to(s + 12);
        stall0_cfg = 1000;
        start = 1'b1;
        s = cyc;
        wait_to(s + 1);
        start = 1'b0;
        wait_to(s + 10);
        check("to_read_c10", {31'd0, bus.avm_read}, 32'd1);
        wait_to(s + 11);
        $display("timeout: read=%0b done=%0b timeout=%0b", bus.avm_read, done, timeout);
        check("to_read_drop", {31'd0, bus.avm_read}, 32'd0);
        check("to_done", {31'd0, done}, 32'd1);
        check("to_flag", {31'd0, timeout}, 32'd1);
        check("to_id_ok", {31'd0, id_ok}, 32'd0);
        check("to_ts_ok", {31'd0, ts_ok}, 32'd0);
        stall0_cfg = 0;
`endif

        wait_to(cyc + 3);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    // Global bound on run length
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
